// File: rtl/gpiomem_pkg.sv
// Shared types and address map constants for the GPIO/data memory arbiter.
package gpiomem_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam int unsigned GPIO_RO_LO = 503;
    localparam int unsigned GPIO_RO_HI = 505;
    localparam int unsigned LED_BASE   = 506;
    localparam int unsigned DIGIT_BASE = 508;

    typedef logic [8:0] addr_t;
    typedef logic [7:0] byte_t;

endpackage

// File: rtl/gpiomem_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after start, wrapping.
module rr_pick #(
    parameter int unsigned N     = 3,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     eligible,
    input  logic [IDX_W-1:0] start,
    output logic [IDX_W-1:0] winner,
    output logic             valid
);

    always_comb begin
        logic [IDX_W:0] k;
        k      = '0;
        winner = '0;
        valid  = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            k = {1'b0, start} + (IDX_W + 1)'(i);
            if (k >= (IDX_W + 1)'(N)) begin
                k = k - (IDX_W + 1)'(N);
            end
            if (!valid && eligible[k[IDX_W-1:0]]) begin
                valid  = 1'b1;
                winner = k[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/gpiomem_arbiter.sv
// Round-robin req/ack arbiter for the single byte-wide GPIO/data memory port,
// with a read-only MMIO window and bounded locked sequences for RMW.
module gpiomem_arbiter
    import gpiomem_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 3,
    parameter int unsigned ADDR_W   = 9,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned RO_LO    = GPIO_RO_LO,
    parameter int unsigned RO_HI    = GPIO_RO_HI,
    parameter int unsigned MAX_LOCK = 4,
    localparam int unsigned GID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          we,
    input  logic [NUM_REQ-1:0]          lock,
    input  logic [NUM_REQ*ADDR_W-1:0]   addr,
    input  logic [NUM_REQ*DATA_W-1:0]   wdata,
    output logic [NUM_REQ-1:0]          ack,
    output logic [NUM_REQ-1:0]          err,
    output logic [DATA_W-1:0]           rdata,
    output logic                        busy,
    output logic [GID_W-1:0]            grant_id,
    output logic                        mem_rw,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata
);

    localparam int unsigned CNT_W = $clog2(MAX_LOCK) + 1;

    state_t             state, state_nx;
    logic [GID_W-1:0]   gid;
    logic [CNT_W-1:0]   lock_cnt, cnt_nx;
    logic               lat_we;
    logic               ro_hit;
    logic               hold;
    logic [NUM_REQ-1:0] eligible;
    logic [GID_W-1:0]   start;
    logic [GID_W-1:0]   pick_w, grant_w;
    logic               pick_v, grant_v;

    // mem_addr/mem_wdata are the request latch itself, so they hold outside ACCESS.
    assign ro_hit   = (mem_addr >= ADDR_W'(RO_LO)) && (mem_addr <= ADDR_W'(RO_HI));
    assign mem_rw   = (state == ACCESS) && lat_we && !ro_hit;
    assign busy     = (state != IDLE);
    assign grant_id = gid;

    always_comb begin
        start    = (gid == GID_W'(NUM_REQ - 1)) ? '0 : gid + 1'b1;
        hold     = (state == RESP) && req[gid] && lock[gid] &&
                   (lock_cnt < CNT_W'(MAX_LOCK - 1));
        eligible = req;
        if (state == RESP) begin
            eligible[gid] = 1'b0;
        end
    end

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (GID_W)
    ) u_pick (
        .eligible (eligible),
        .start    (start),
        .winner   (pick_w),
        .valid    (pick_v)
    );

    // A locked requester under its limit keeps the port ahead of round-robin;
    // at the limit it is masked, but re-granted if nobody else is waiting.
    always_comb begin
        state_nx = state;
        grant_v  = 1'b0;
        grant_w  = pick_w;
        cnt_nx   = '0;
        case (state)
            IDLE: begin
                if (pick_v) begin
                    grant_v  = 1'b1;
                    state_nx = ACCESS;
                end
            end
            ACCESS: state_nx = RESP;
            RESP: begin
                state_nx = IDLE;
                if (hold) begin
                    grant_v = 1'b1;
                    grant_w = gid;
                    cnt_nx  = lock_cnt + 1'b1;
                end else if (pick_v) begin
                    grant_v = 1'b1;
                end else if (req[gid] && lock[gid]) begin
                    grant_v = 1'b1;
                    grant_w = gid;
                end
                if (grant_v) begin
                    state_nx = ACCESS;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            gid       <= GID_W'(NUM_REQ - 1);
            lock_cnt  <= '0;
            lat_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ack       <= '0;
            err       <= '0;
            rdata     <= '0;
        end else begin
            state <= state_nx;
            ack   <= '0;
            err   <= '0;
            if (state == ACCESS) begin
                ack[gid] <= 1'b1;
                err[gid] <= lat_we && ro_hit;
                rdata    <= mem_rdata;
            end
            if (grant_v) begin
                gid       <= grant_w;
                lock_cnt  <= cnt_nx;
                lat_we    <= we[grant_w];
                mem_addr  <= addr[int'(grant_w) * ADDR_W +: ADDR_W];
                mem_wdata <= wdata[int'(grant_w) * DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: tb/tb_gpiomem_arbiter.sv
// Directed self-checking bench for gpiomem_arbiter with a behavioural 512-byte memory.
module tb_gpiomem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_init;
    logic [2:0]  req, we, lock;
    logic [26:0] addr;
    logic [23:0] wdata;
    logic [2:0]  ack, err;
    logic [7:0]  rdata;
    logic        busy;
    logic [1:0]  grant_id;
    logic        mem_rw;
    logic [8:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic [7:0]  mem [512];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gpiomem_arbiter #(
        .NUM_REQ  (3),
        .ADDR_W   (9),
        .DATA_W   (8),
        .RO_LO    (503),
        .RO_HI    (505),
        .MAX_LOCK (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .lock      (lock),
        .addr      (addr),
        .wdata     (wdata),
        .ack       (ack),
        .err       (err),
        .rdata     (rdata),
        .busy      (busy),
        .grant_id  (grant_id),
        .mem_rw    (mem_rw),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 512; i++) mem[i] <= 8'(i) ^ 8'hA5;
            mem[16]  <= 8'h5A;
            mem[17]  <= 8'h3C;
            mem[18]  <= 8'hC3;
            mem[32]  <= 8'h11;
            mem[504] <= 8'h0C;
            mem[506] <= 8'h00;
        end else if (mem_rw) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int r, input logic [8:0] a, input logic [7:0] d, input logic w);
        addr[r*9 +: 9]  = a;
        wdata[r*8 +: 8] = d;
        we[r]           = w;
    endtask

    initial begin
        int         cont_g [4];
        logic [7:0] cont_d [4];
        int         lock_g [6];
        logic [7:0] lock_d [6];
        logic [2:0] oh;

        cont_g = '{1, 2, 0, 1};
        cont_d = '{8'h3C, 8'hC3, 8'h5A, 8'h3C};
        lock_g = '{2, 2, 2, 2, 0, 1};
        lock_d = '{8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'h5A, 8'h3C};

        reset = 1'b1; mem_init = 1'b1;
        req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
        repeat (2) tick();
        mem_init = 1'b0;

        check("rst_ack",       32'(ack),       32'h0);
        check("rst_err",       32'(err),       32'h0);
        check("rst_rdata",     32'(rdata),     32'h0);
        check("rst_busy",      32'(busy),      32'h0);
        check("rst_mem_rw",    32'(mem_rw),    32'h0);
        check("rst_mem_addr",  32'(mem_addr),  32'h0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        check("rst_grant_id",  32'(grant_id),  32'h2);
        reset = 1'b0;

        // single read by requester 0
        set_port(0, 9'h010, 8'h00, 1'b0);
        req = 3'b001;
        tick();
        check("rd_access_busy", 32'(busy),     32'h1);
        check("rd_access_addr", 32'(mem_addr), 32'h010);
        check("rd_access_rw",   32'(mem_rw),   32'h0);
        check("rd_access_gid",  32'(grant_id), 32'h0);
        check("rd_access_ack",  32'(ack),      32'h0);
        tick();
        check("rd_ack",   32'(ack),   32'h1);
        check("rd_data",  32'(rdata), 32'h5A);
        check("rd_err",   32'(err),   32'h0);
        req = 3'b000;
        tick();
        check("rd_idle_busy", 32'(busy), 32'h0);
        check("rd_idle_ack",  32'(ack),  32'h0);

        // contention, last grant was 0
        set_port(1, 9'h011, 8'h00, 1'b0);
        set_port(2, 9'h012, 8'h00, 1'b0);
        req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("cont_gid",     32'(grant_id), 32'(cont_g[k]));
            check("cont_gap_ack", 32'(ack),      32'h0);
            tick();
            oh = 3'b001 << cont_g[k];
            check("cont_ack",   32'(ack),   32'(oh));
            check("cont_rdata", 32'(rdata), 32'(cont_d[k]));
        end
        req = 3'b000;
        tick();
        check("cont_idle_busy", 32'(busy), 32'h0);

        // write into read-only window is suppressed
        set_port(1, 9'd504, 8'hFF, 1'b1);
        req = 3'b010;
        tick();
        check("ro_gid",   32'(grant_id),  32'h1);
        check("ro_rw",    32'(mem_rw),    32'h0);
        check("ro_addr",  32'(mem_addr),  32'd504);
        check("ro_wdata", 32'(mem_wdata), 32'hFF);
        tick();
        check("ro_ack", 32'(ack), 32'h2);
        check("ro_err", 32'(err), 32'h2);
        check("ro_mem", 32'(mem[504]), 32'h0C);
        req = 3'b000;
        tick();

        // write just above the window goes through
        set_port(1, 9'd506, 8'h5A, 1'b1);
        req = 3'b010;
        tick();
        check("led_rw", 32'(mem_rw), 32'h1);
        tick();
        check("led_ack", 32'(ack), 32'h2);
        check("led_err", 32'(err), 32'h0);
        check("led_mem", 32'(mem[506]), 32'h5A);
        req = 3'b000; we = 3'b000;
        tick();
        check("led_after_rw", 32'(mem_rw), 32'h0);

        // locked requester 2: four grants, then forced rotation
        set_port(1, 9'h011, 8'h00, 1'b0);
        req = 3'b111; lock = 3'b100;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("lock_gid", 32'(grant_id), 32'(lock_g[k]));
            tick();
            oh = 3'b001 << lock_g[k];
            check("lock_ack",   32'(ack),   32'(oh));
            check("lock_rdata", 32'(rdata), 32'(lock_d[k]));
            if (k >= 3) req[lock_g[k]] = 1'b0;
            if (k == 3) lock = 3'b000;
        end
        tick();
        check("lock_idle_busy", 32'(busy), 32'h0);

        // back-to-back single requester: held past ack, served once
        req = 3'b001;
        tick();
        check("b2b_gid", 32'(grant_id), 32'h0);
        tick();
        check("b2b_ack", 32'(ack), 32'h1);
        tick();
        check("b2b_masked_busy", 32'(busy), 32'h0);
        check("b2b_masked_ack",  32'(ack),  32'h0);
        req = 3'b000;
        tick();
        check("b2b_idle_ack", 32'(ack), 32'h0);

        // reset in the middle of a write access
        set_port(1, 9'h020, 8'h33, 1'b1);
        req = 3'b010;
        tick();
        check("mid_access_rw", 32'(mem_rw), 32'h1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_rw",       32'(mem_rw),    32'h0);
        check("mid_rst_busy",     32'(busy),      32'h0);
        check("mid_rst_ack",      32'(ack),       32'h0);
        check("mid_rst_gid",      32'(grant_id),  32'h2);
        check("mid_rst_addr",     32'(mem_addr),  32'h0);
        check("mid_rst_wdata",    32'(mem_wdata), 32'h0);
        check("mid_rst_rdata",    32'(rdata),     32'h0);
        tick();
        check("mid_rst_mem",      32'(mem[32]),   32'h11);
        check("mid_rst_ack2",     32'(ack),       32'h0);
        we = 3'b000; req = 3'b011;
        reset = 1'b0;
        tick();
        check("post_rst_gid", 32'(grant_id), 32'h0);
        tick();
        check("post_rst_ack",   32'(ack),   32'h1);
        check("post_rst_rdata", 32'(rdata), 32'h5A);
        req = 3'b000;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
